// File: rtl/freq_multiplier.sv
// freq_multiplier: measures the clk period of a slow strobe and emits MULT evenly spaced ticks per period.
// Latency: all outputs registered; a tick decided in cycle k is visible in cycle k+1. No backpressure.
// Optional FREQMUL_PHASE_OUT_EN adds phase_idx, the index of the most recent tick.
module freq_multiplier #(
    parameter int MULT  = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             sta_user,
    input  logic             signal_in,
    output logic             signal_out,
    output logic             locked,
    output logic [WIDTH-1:0] period_out
`ifdef FREQMUL_PHASE_OUT_EN
    ,
    output logic [$clog2(MULT)-1:0] phase_idx
`endif
);

    localparam int SW = $clog2(MULT);
    localparam logic [SW-1:0]  SUB_MAX = SW'(MULT - 1);
    localparam logic [WIDTH:0] MULT_W  = (WIDTH + 1)'(MULT);

    typedef enum logic [1:0] {IDLE, MEASURE, RUN} state_t;

    state_t           state, state_nxt;
    logic             prev_in;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH:0]   acc, acc_nxt;
    logic [SW-1:0]    sub_cnt, sub_nxt;
    logic [WIDTH-1:0] period_nxt;
    logic             locked_nxt;
    logic             tick_nxt;

    logic             edge_det;
    logic             timeout;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH:0]   period_ext;

    assign edge_det   = signal_in & ~prev_in;
    assign timeout    = (cnt == '1) & ~edge_det;
    assign acc_sum    = acc + MULT_W;
    assign period_ext = {1'b0, period_out};
    // Saturate so a stalled strobe cannot wrap the counter and fake a short period.
    assign cnt_nxt    = edge_det ? WIDTH'(1) : ((cnt == '1) ? cnt : cnt + WIDTH'(1));

    always_ff @(posedge clk or posedge sta_user) begin
        if (sta_user) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (edge_det) state_nxt = MEASURE;
            MEASURE: begin
                if (edge_det)     state_nxt = RUN;
                else if (timeout) state_nxt = IDLE;
            end
            RUN:     if (timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tick_nxt   = 1'b0;
        acc_nxt    = acc;
        sub_nxt    = sub_cnt;
        period_nxt = period_out;
        locked_nxt = locked;
        if (state == MEASURE || state == RUN) begin
            if (edge_det) begin
                tick_nxt   = 1'b1;
                period_nxt = cnt;
                locked_nxt = 1'b1;
                acc_nxt    = '0;
                sub_nxt    = '0;
            end else if (timeout) begin
                locked_nxt = 1'b0;
            end else if (state == RUN && sub_cnt != SUB_MAX) begin
                // Bresenham step: one sub-tick each time MULT*t crosses another period.
                if (acc_sum >= period_ext) begin
                    tick_nxt = 1'b1;
                    acc_nxt  = acc_sum - period_ext;
                    sub_nxt  = sub_cnt + SW'(1);
                end else begin
                    acc_nxt  = acc_sum;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge sta_user) begin
        if (sta_user) begin
            prev_in    <= 1'b1;
            cnt        <= '0;
            acc        <= '0;
            sub_cnt    <= '0;
            period_out <= '0;
            locked     <= 1'b0;
            signal_out <= 1'b0;
        end else begin
            prev_in    <= signal_in;
            cnt        <= cnt_nxt;
            acc        <= acc_nxt;
            sub_cnt    <= sub_nxt;
            period_out <= period_nxt;
            locked     <= locked_nxt;
            signal_out <= tick_nxt;
        end
    end

`ifdef FREQMUL_PHASE_OUT_EN
    // The tick index always equals the post-tick sub-count (0 on the edge tick).
    always_ff @(posedge clk or posedge sta_user) begin
        if (sta_user) begin
            phase_idx <= '0;
        end else if (tick_nxt) begin
            phase_idx <= sub_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_freq_multiplier.sv
// Bench for freq_multiplier: directed and random strobe patterns against a tick-schedule model.
module tb_freq_multiplier;
    localparam int M    = 4;
    localparam int W    = 8;
    localparam int TOUT = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         sta_user = 1'b1;
    logic         signal_in = 1'b0;
    logic         signal_out;
    logic         locked;
    logic [W-1:0] period_out;
`ifdef FREQMUL_PHASE_OUT_EN
    logic [$clog2(M)-1:0] phase_idx;
`endif

    freq_multiplier #(.MULT(M), .WIDTH(W)) dut (
        .clk        (clk),
        .sta_user   (sta_user),
        .signal_in  (signal_in),
        .signal_out (signal_out),
        .locked     (locked),
        .period_out (period_out)
`ifdef FREQMUL_PHASE_OUT_EN
        ,
        .phase_idx  (phase_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int ph;
    } tick_t;
    typedef enum {M_IDLE, M_MEAS, M_RUN} mst_t;

    tick_t tq[$];
    mst_t  mst;
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    bit    mprev, mlocked, exp_tick;
    int    mperiod, mlast, mph;

    function automatic void model_reset();
        mst     = M_IDLE;
        mprev   = 1'b1;
        mlocked = 1'b0;
        mperiod = 0;
        mlast   = 0;
        mph     = 0;
        tq.delete();
    endfunction

    // Schedule: tick j of a period P falls max(ceil(j*P/M), j) cycles after the edge tick.
    function automatic void model_cycle(input bit s);
        bit    e_now;
        int    p;
        int    off;
        tick_t nq[$];
        e_now = s && !mprev;
        mprev = s;
        if (e_now) begin
            if (mst == M_IDLE) begin
                mst = M_MEAS;
            end else begin
                p       = cyc - mlast;
                mperiod = p;
                mlocked = 1'b1;
                mst     = M_RUN;
                tq.delete();
                for (int j = 0; j < M; j++) begin
                    off = (j * p + M - 1) / M;
                    if (off < j) off = j;
                    tq.push_back('{cyc + off, j});
                end
            end
            mlast = cyc;
        end else if (mst != M_IDLE && (cyc - mlast) == TOUT) begin
            mst     = M_IDLE;
            mlocked = 1'b0;
        end
        exp_tick = 1'b0;
        foreach (tq[i]) begin
            if (tq[i].c == cyc) begin
                exp_tick = 1'b1;
                mph      = tq[i].ph;
            end
        end
        foreach (tq[i]) if (tq[i].c > cyc) nq.push_back(tq[i]);
        tq = nq;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic compare_all();
        check("signal_out", {31'd0, signal_out}, {31'd0, exp_tick});
        check("locked", {31'd0, locked}, {31'd0, mlocked});
        check("period_out", {24'd0, period_out}, mperiod);
`ifdef FREQMUL_PHASE_OUT_EN
        check("phase_idx", {30'd0, phase_idx}, mph);
`endif
    endtask

    task automatic step(input bit s);
        signal_in = s;
        @(posedge clk);
        cyc++;
        model_cycle(s);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_period(input int p, input int hi);
        for (int i = 0; i < p; i++) step(i < hi);
    endtask

    task automatic do_reset(input bit s);
        sta_user  = 1'b1;
        signal_in = s;
        model_reset();
        exp_tick  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            compare_all();
        end
        sta_user = 1'b0;
    endtask

    initial begin
        int p;
        int hi;
        do_reset(1'b0);
        repeat (3) step(1'b0);

        // Stable periods, then a short period cutting off a pending sub-tick.
        repeat (4) run_period(20, 1);
        repeat (3) run_period(10, 3);
        run_period(20, 1);
        run_period(8, 1);
        repeat (2) run_period(8, 2);
        repeat (2) run_period(10, 1);
        run_period(40, 5);

        // Strobe stalls: sub-ticks cap, then lock drops after TOUT cycles; two edges relock.
        repeat (2) run_period(20, 1);
        signal_in = 1'b1;
        step(1'b1);
        repeat (300) step(1'b0);
        repeat (3) run_period(20, 1);

        // Periods shorter than MULT.
        repeat (3) run_period(2, 1);
        repeat (3) run_period(3, 1);
        repeat (2) run_period(5, 2);

        repeat (30) begin
            p  = int'($urandom_range(60, 2));
            hi = int'($urandom_range(p - 1, 1));
            run_period(p, hi);
        end

        // Reset mid-RUN, then relock.
        repeat (2) run_period(20, 1);
        repeat (7) step(1'b0);
        do_reset(1'b0);
        repeat (3) run_period(20, 1);

        // Strobe already high at reset release must not count as an edge.
        do_reset(1'b1);
        repeat (3) step(1'b1);
        step(1'b0);
        repeat (3) run_period(12, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
